ddr_tx_serializer: RTL and testbench

Transmit-side serializer that is the output counterpart of the I_DDR capture path. It accepts parallel words through a valid/ready handshake, buffers them in a small FIFO, and emits two bits per clock on a registered pair intended for an O_DDR primitive's D inputs. It also drives the output-enable of the downstream tristate differential buffer (O_BUFT_DS), so the pad is only driven while a burst is in flight.

---
 rtl/ddr_tx_serializer.sv | 129 ++++++++++++
 tb/tb_ddr_tx_serializer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_tx_serializer.sv
// Transmit serializer: a small FIFO feeds a lead/shift/trail FSM that emits two bits
// per clock on a registered pair for an O_DDR primitive, plus the pad output-enable.
module ddr_tx_serializer #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [1:0]        ddr_d,
    output logic              out_en,
    output logic              busy,
    output logic              underrun,
    output logic [15:0]       tx_count
);

    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int BEATS  = DATA_W / 2;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic              push, pop, empty, last_beat;
    logic [DATA_W-1:0] head;

    state_t            state;
    logic [BEAT_W-1:0] beat;
    logic [DATA_W-1:0] shift_reg;

    always_comb begin
        empty      = (wr_ptr == rd_ptr);
        head       = mem[rd_ptr[AW-1:0]];
        last_beat  = (state == SHIFT) && (beat == LAST_BEAT);
        push       = in_valid && in_ready;
        // LEAD is only entered with a non-empty FIFO, so its exit pop is always legal.
        pop        = (state == LEAD) || (last_beat && en && !empty);
        wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, push};
        rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};
    end

    // NOTE: in_ready is registered from the post-edge pointers, so a pop on a full
    // FIFO frees the slot for the following edge, not the current one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            in_ready <= 1'b1;
        end else begin
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            in_ready <= !((wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                          (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]));
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            beat      <= '0;
            shift_reg <= '0;
            ddr_d     <= 2'b00;
            out_en    <= 1'b0;
            busy      <= 1'b0;
            underrun  <= 1'b0;
            tx_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && !empty) begin
                        state  <= LEAD;
                        out_en <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                LEAD: begin
                    state     <= SHIFT;
                    beat      <= '0;
                    ddr_d     <= head[1:0];
                    shift_reg <= head >> 2;
                end
                SHIFT: begin
                    if (beat == LAST_BEAT) begin
                        tx_count <= tx_count + 16'd1;
                        if (en && !empty) begin
                            beat      <= '0;
                            ddr_d     <= head[1:0];
                            shift_reg <= head >> 2;
                        end else begin
                            state <= TRAIL;
                            ddr_d <= 2'b00;
                            if (!en && !empty) begin
                                underrun <= 1'b1;
                            end
                        end
                    end else begin
                        beat      <= beat + BEAT_W'(1);
                        ddr_d     <= shift_reg[1:0];
                        shift_reg <= shift_reg >> 2;
                    end
                end
                TRAIL: begin
                    state  <= IDLE;
                    out_en <= 1'b0;
                    busy   <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    ddr_d  <= 2'b00;
                    out_en <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_tx_serializer.sv
// Bench for ddr_tx_serializer: directed timing scenarios plus randomized traffic, with
// every output burst decoded back into words and matched against the queue of pushed words.
module tb_ddr_tx_serializer;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int BEATS      = DATA_W / 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        ddr_d;
    logic              out_en;
    logic              busy;
    logic              underrun;
    logic [15:0]       tx_count;

    // Second instance with 2-bit words (one beat per word) for the counter wrap.
    logic              en_w;
    logic [1:0]        in_data_w;
    logic              in_valid_w;
    logic              in_ready_w;
    logic [1:0]        ddr_d_w;
    logic              out_en_w;
    logic              busy_w;
    logic              underrun_w;
    logic [15:0]       tx_count_w;

    ddr_tx_serializer #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .en(en), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .ddr_d(ddr_d), .out_en(out_en), .busy(busy),
        .underrun(underrun), .tx_count(tx_count)
    );

    ddr_tx_serializer #(.DATA_W(2), .FIFO_DEPTH(4)) dut_w (
        .clk(clk), .rst(rst), .en(en_w), .in_data(in_data_w), .in_valid(in_valid_w),
        .in_ready(in_ready_w), .ddr_d(ddr_d_w), .out_en(out_en_w), .busy(busy_w),
        .underrun(underrun_w), .tx_count(tx_count_w)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: words accepted and not yet seen on the output, in order.
    logic [DATA_W-1:0] model_q [$];
    int                push_cnt = 0;

    always @(posedge clk) begin
        if (!rst && in_valid && in_ready) begin
            model_q.push_back(in_data);
            push_cnt++;
        end
    end

    // Burst decoder: a burst is a run of out_en=1 cycles: one 00 lead cycle,
    // an integral number of words at BEATS cycles each, one 00 trail cycle.
    logic [1:0] beats [$];

    task automatic finish_burst();
        int                n;
        logic [1:0]        b;
        logic [DATA_W-1:0] word;
        logic [DATA_W-1:0] exp;
        n = beats.size();
        check("burst_len_min", n >= 3, 1'b1);
        if (n >= 3) begin
            check("lead_00", beats[0], 2'b00);
            check("trail_00", beats[n-1], 2'b00);
            check("burst_len_mod", (n - 2) % BEATS, 0);
            for (int w = 0; w < (n - 2) / BEATS; w++) begin
                word = '0;
                for (int k = 0; k < BEATS; k++) begin
                    b = beats[1 + w * BEATS + k];
                    word[2*k]   = b[0];
                    word[2*k+1] = b[1];
                end
                check("word_pending", model_q.size() > 0, 1'b1);
                if (model_q.size() > 0) begin
                    exp = model_q.pop_front();
                    check("word", word, exp);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            beats.delete();
        end else begin
            check("busy_eq_oe", busy, out_en);
            if (out_en) begin
                beats.push_back(ddr_d);
            end else if (beats.size() > 0) begin
                finish_burst();
                beats.delete();
            end
        end
    end

    logic seen_ffff = 1'b0;
    always @(negedge clk) begin
        if (tx_count_w == 16'hFFFF) seen_ffff = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks ddr_d/out_en for n consecutive cycles, the first at the current time.
    task automatic expect_stream(input string tag, input int n,
                                 input logic [63:0] dseq, input logic [31:0] oeseq);
        for (int i = 0; i < n; i++) begin
            if (i > 0) tick();
            check({tag, "_d"}, ddr_d, dseq[2*i +: 2]);
            check({tag, "_oe"}, out_en, oeseq[i]);
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((model_q.size() != 0 || out_en) && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_drain_in_budget"}, n < budget, 1'b1);
    endtask

    initial begin
        int n;
        int acc;
        logic r;
        logic seen_oe;

        rst = 1'b1; en = 1'b0; in_data = '0; in_valid = 1'b0;
        en_w = 1'b0; in_data_w = '0; in_valid_w = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        tick();

        check("rst_out_en", out_en, 1'b0);
        check("rst_ddr_d", ddr_d, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_underrun", underrun, 1'b0);
        check("rst_tx_count", tx_count, 16'd0);
        check("rst_in_ready", in_ready, 1'b1);

        // Single word 0xB4: LEAD, beats 00 01 11 10, TRAIL, IDLE.
        en = 1'b1; in_data = 8'hB4; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("single_idle_after_push", out_en, 1'b0);
        tick();
        expect_stream("single", 7, 64'h2D0, 32'h3F);
        wait_idle("single", 20);
        check("single_tx_count", tx_count, 16'd1);

        // Back-to-back 0xFF, 0x00 with no gap between words.
        in_data = 8'hFF; in_valid = 1'b1;
        tick();
        in_data = 8'h00;
        tick();
        in_valid = 1'b0;
        expect_stream("b2b", 11, 64'h3FC, 32'h3FF);
        wait_idle("b2b", 20);
        check("b2b_tx_count", tx_count, 16'd3);

        // FIFO full with en low: four accepted, fifth held until a slot frees.
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_data = DATA_W'($urandom); in_valid = 1'b1;
            check("fill_ready", in_ready, 1'b1);
            tick();
        end
        in_data = DATA_W'($urandom);
        for (int i = 0; i < 3; i++) begin
            check("full_ready_low", in_ready, 1'b0);
            tick();
        end
        en = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("full_free_latency", n, 2);
        tick();
        in_valid = 1'b0;
        wait_idle("full", 60);
        check("full_tx_count", tx_count, 16'd8);
        check("full_ready_after", in_ready, 1'b1);
        check("full_no_underrun", underrun, 1'b0);

        // en drop during word 1 beat 1 with two more words queued.
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_data = DATA_W'($urandom); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        en = 1'b1;
        tick();
        check("drop_lead_oe", out_en, 1'b1);
        tick();
        tick();
        en = 1'b0;
        n = 0;
        while (out_en && n < 10) begin
            tick();
            n++;
        end
        check("drop_cycles_to_idle", n, 4);
        check("drop_underrun", underrun, 1'b1);
        check("drop_tx_count", tx_count, 16'd9);
        seen_oe = 1'b0;
        repeat (5) begin
            tick();
            seen_oe |= out_en;
        end
        check("drop_stays_idle", seen_oe, 1'b0);
        check("drop_remaining", model_q.size(), 2);
        en = 1'b1;
        wait_idle("resume", 40);
        check("resume_tx_count", tx_count, 16'd11);
        check("resume_underrun_sticky", underrun, 1'b1);

        // Reset during beat 2 of the first of two queued words.
        in_data = DATA_W'($urandom); in_valid = 1'b1;
        tick();
        in_data = DATA_W'($urandom);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check("midrst_out_en", out_en, 1'b0);
        check("midrst_ddr_d", ddr_d, 2'b00);
        check("midrst_busy", busy, 1'b0);
        check("midrst_tx_count", tx_count, 16'd0);
        check("midrst_underrun", underrun, 1'b0);
        model_q.delete();
        push_cnt = 0;
        #3 rst = 1'b0;
        tick();
        check("midrst_in_ready", in_ready, 1'b1);
        seen_oe = 1'b0;
        repeat (8) begin
            tick();
            seen_oe |= out_en;
        end
        check("midrst_no_stale", seen_oe, 1'b0);
        in_data = DATA_W'($urandom); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_idle("post_rst", 20);
        check("post_rst_tx_count", tx_count, 16'd1);

        // Randomized traffic with occasional en drops, then drain everything.
        for (int i = 0; i < 600; i++) begin
            in_valid = 1'($urandom % 2);
            in_data  = DATA_W'($urandom);
            en       = ($urandom % 6) != 0;
            tick();
        end
        in_valid = 1'b0;
        en = 1'b1;
        wait_idle("rand", 400);
        check("rand_tx_count", tx_count, push_cnt[15:0]);
        check("rand_ready", in_ready, 1'b1);

        // Counter wrap: 65536 streamed one-beat words bring tx_count back to 0.
        en_w = 1'b1; in_valid_w = 1'b1;
        acc = 0;
        n = 0;
        while (acc < 65536 && n < 70000) begin
            in_data_w = 2'($urandom);
            r = in_ready_w;
            tick();
            if (r) acc++;
            n++;
        end
        in_valid_w = 1'b0;
        check("wrap_pushes", acc, 65536);
        n = 0;
        while (busy_w && n < 20) begin
            tick();
            n++;
        end
        check("wrap_drain_in_budget", n < 20, 1'b1);
        check("wrap_ffff_seen", seen_ffff, 1'b1);
        check("wrap_zero", tx_count_w, 16'd0);
        in_valid_w = 1'b1;
        tick();
        in_valid_w = 1'b0;
        tick();
        n = 0;
        while (busy_w && n < 20) begin
            tick();
            n++;
        end
        check("wrap_one", tx_count_w, 16'd1);
        check("wrap_no_underrun", underrun_w, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
